// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture/readout slice.
package scope_pkg;

  localparam int TRACE_AW = 9;
  localparam int SMPL_DW  = 8;
  localparam logic [7:0] UNITY_GAIN = 8'h20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    CORR = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } dump_state_t;

endpackage

// File: rtl/smpl_correct.sv
// Combinational per-sample offset add, clamp to 0..max, gain multiply, shift and saturate.
// Zero latency; no handshake (caller registers the result).
module smpl_correct #(
  parameter int DW         = 8,
  parameter int GAIN_SHIFT = 5
) (
  input  logic [DW-1:0] raw,
  input  logic [7:0]    gain,
  input  logic [7:0]    offset,
  output logic [DW-1:0] corr
);

  logic signed [DW+1:0] s;
  logic [DW-1:0]        s_cl;
  logic [DW+7:0]        p;
  logic [DW+7:0]        r;

  assign s = $signed({2'b00, raw}) + $signed({{(DW-6){offset[7]}}, offset});

  // s spans -128..2**DW+126, so the top two bits fully classify under/overflow
  always_comb begin
    s_cl = s[DW-1:0];
    if (s[DW+1])
      s_cl = '0;
    else if (s[DW])
      s_cl = '1;
  end

  assign p    = {8'd0, s_cl} * {{DW{1'b0}}, gain};
  assign r    = p >> GAIN_SHIFT;
  assign corr = (|r[DW+7:DW]) ? '1 : r[DW-1:0];

endmodule

// File: rtl/trace_dump.sv
// Chronological trace RAM readout with gain/offset correction; 4 cycles/sample, stalls in SEND on !tx_rdy.
// Optional abort input enabled by TRACE_DUMP_ABORT_EN.
module trace_dump
  import scope_pkg::*;
#(
  parameter int AW         = TRACE_AW,
  parameter int DW         = SMPL_DW,
  parameter int GAIN_SHIFT = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] trace_end,
  input  logic [7:0]    gain,
  input  logic [7:0]    offset,
`ifdef TRACE_DUMP_ABORT_EN
  input  logic          abort,
`endif
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_rdy,
  output logic          busy,
  output logic          dump_done,
  output logic          clr_cap_done
);

  dump_state_t   state, state_nxt;
  logic [7:0]    gain_q, offset_q;
  logic [DW-1:0] raw_q, corr;
  logic [AW-1:0] cnt;
  logic          abort_req;
  logic          last_smpl;

`ifdef TRACE_DUMP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_smpl = &cnt;

  smpl_correct #(.DW(DW), .GAIN_SHIFT(GAIN_SHIFT)) u_corr (
    .raw    (raw_q),
    .gain   (gain_q),
    .offset (offset_q),
    .corr   (corr)
  );

  always_comb begin
    state_nxt    = state;
    ram_en       = 1'b0;
    tx_valid     = 1'b0;
    busy         = 1'b1;
    dump_done    = 1'b0;
    clr_cap_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = READ;
      end
      READ: begin
        ram_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = CORR;
      CORR: state_nxt = SEND;
      SEND: begin
        tx_valid = 1'b1;
        if (tx_rdy) state_nxt = last_smpl ? DONE : READ;
      end
      DONE: begin
        dump_done    = 1'b1;
        clr_cap_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // abort outranks any handshake completing in the same cycle
    if (abort_req && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ram_addr <= '0;
      tx_data  <= '0;
      cnt      <= '0;
      gain_q   <= '0;
      offset_q <= '0;
      raw_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          gain_q   <= gain;
          offset_q <= offset;
          ram_addr <= trace_end + AW'(1);
          cnt      <= '0;
        end
        WAIT: raw_q <= ram_rdata;
        CORR: tx_data <= corr;
        SEND: if (tx_rdy && !last_smpl && !abort_req) begin
          cnt      <= cnt + AW'(1);
          ram_addr <= ram_addr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_dump.sv
// Directed/randomized bench for trace_dump with a RAM model and an arithmetic correction reference.
module tb_trace_dump;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] trace_end = '0;
  logic [7:0] gain = '0;
  logic [7:0] offset = '0;
  logic       ram_en;
  logic [8:0] ram_addr;
  logic [7:0] ram_rdata = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_rdy = 1'b1;
  logic       busy;
  logic       dump_done;
  logic       clr_cap_done;
`ifdef TRACE_DUMP_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  trace_dump dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .trace_end    (trace_end),
    .gain         (gain),
    .offset       (offset),
`ifdef TRACE_DUMP_ABORT_EN
    .abort        (abort),
`endif
    .ram_en       (ram_en),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_rdy       (tx_rdy),
    .busy         (busy),
    .dump_done    (dump_done),
    .clr_cap_done (clr_cap_done)
  );

  logic [7:0] mem [512];

  always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

  int n_assert = 0;
  int n_fail   = 0;

  // monitor state, sampled on the falling edge
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         addr_q[$];
  int cyc = 0, done_cnt = 0, clr_cnt = 0, coinc_err = 0, hold_err = 0, stall_cyc = 0;
  int last_hs_cyc = 0, done_cyc = 0;
  bit hold_en = 1'b1;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (ram_en) addr_q.push_back(int'(ram_addr));
    if (tx_valid && tx_rdy) begin
      obs_q.push_back(tx_data);
      last_hs_cyc = cyc;
    end
    if (tx_valid && !tx_rdy) stall_cyc++;
    if (dump_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (clr_cap_done) clr_cnt++;
    if (dump_done !== clr_cap_done) coinc_err++;
    if (hold_en && prev_stall && (!tx_valid || tx_data !== prev_data || ram_en)) hold_err++;
    prev_stall = tx_valid && !tx_rdy && !rst;
    prev_data  = tx_data;
  end

  function automatic logic [7:0] corr_ref(input logic [7:0] raw, input logic [7:0] g,
                                          input logic [7:0] off);
    int s, r;
    s = int'(raw) + int'($signed(off));
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    r = (s * int'(g)) / 32;
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dump_done"}, dump_done, 0);
    chk({tag, "_clr_cap_done"}, clr_cap_done, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
  endtask

  task automatic start_dump(input logic [8:0] te, input logic [7:0] g, input logic [7:0] off);
    @(posedge clk); #1;
    obs_q.delete(); addr_q.delete(); exp_q.delete();
    done_cnt = 0; clr_cnt = 0; coinc_err = 0; hold_err = 0; stall_cyc = 0;
    for (int k = 0; k < 512; k++) exp_q.push_back(corr_ref(mem[(int'(te) + 1 + k) % 512], g, off));
    start = 1'b1; trace_end = te; gain = g; offset = off; tx_rdy = 1'b1;
    sample();
    chk("idle_at_start", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    trace_end = 9'($urandom); gain = 8'($urandom); offset = 8'($urandom);
    sample();
    chk("first_ram_en", ram_en, 1);
    chk("first_ram_addr", ram_addr, (int'(te) + 1) % 512);
    chk("first_tx_valid", tx_valid, 0);
  endtask

  // mode 0: tx_rdy high; 1: random tx_rdy; 2: one 7-cycle stall in SEND at byte 200
  task automatic run(input int mode, input bit mid_start, input bit start_at_done, input int stop_at);
    int  budget = 6000;
    int  stall_left = 0;
    bit  stalled_once = 0, mid_done = 0;
    while (done_cnt == 0 && !(stop_at >= 0 && obs_q.size() >= stop_at) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      start = 1'b0;
      trace_end = 9'($urandom); gain = 8'($urandom); offset = 8'($urandom);
      case (mode)
        0: tx_rdy = 1'b1;
        1: tx_rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stalled_once && tx_valid && obs_q.size() == 200) begin
            stalled_once = 1;
            stall_left = 7;
          end
          if (stall_left > 0) begin
            tx_rdy = 1'b0;
            stall_left--;
          end else tx_rdy = 1'b1;
        end
      endcase
      if (mid_start && !mid_done && obs_q.size() == 50) begin
        start = 1'b1;
        mid_done = 1;
      end
      if (start_at_done && dump_done) start = 1'b1;
      sample();
    end
    chk("run_within_budget", budget > 0, 1);
  endtask

  task automatic verify(input string tag, input logic [8:0] te);
    chk({tag, "_byte_count"}, obs_q.size(), 512);
    chk({tag, "_read_count"}, addr_q.size(), 512);
    if (obs_q.size() == 512)
      for (int k = 0; k < 512; k++) chk($sformatf("%s_byte%0d", tag, k), obs_q[k], exp_q[k]);
    if (addr_q.size() == 512)
      for (int k = 0; k < 512; k++)
        chk($sformatf("%s_addr%0d", tag, k), addr_q[k], (int'(te) + 1 + k) % 512);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_clr_pulses"}, clr_cnt, 1);
    chk({tag, "_done_clr_coincident"}, coinc_err, 0);
    chk({tag, "_hold_stable"}, hold_err, 0);
    chk({tag, "_done_after_last_hs"}, done_cyc - last_hs_cyc, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cnt;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    sample();
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // identity correction, ram holds its own address
    start_dump(9'd100, 8'h20, 8'h00);
    run(0, 0, 0, -1);
    verify("dumpA", 9'd100);
    chk("dumpA_first_byte", obs_q[0], 8'd101);
    chk("dumpA_last_byte", obs_q[511], 8'd100);
    chk("dumpA_no_stall", stall_cyc, 0);

    // wrap from 511, saturation cases, random backpressure, start mid-dump and at DONE
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[5] = 8'h90; mem[6] = 8'h0A; mem[7] = 8'h20;
    start_dump(9'd511, 8'h40, 8'hF0);
    run(1, 1, 1, -1);
    verify("dumpB", 9'd511);
    chk("corr_saturate_hi", obs_q[5], 8'hFF);
    chk("corr_clamp_lo", obs_q[6], 8'h00);
    chk("corr_mid", obs_q[7], 8'h20);

    // start held from DONE into the following idle cycle starts exactly one new dump
    start_dump(9'($urandom), 8'($urandom), 8'($urandom));
    run(2, 0, 0, -1);
    verify("dumpC", 9'(addr_q[511]));
    chk("dumpC_stall_cycles", stall_cyc, 7);

    // synchronous reset mid-dump, with a coincident start that must lose
    start_dump(9'd300, 8'h33, 8'h05);
    run(0, 0, 0, 37);
    chk("rst_at_sample", obs_q.size(), 37);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    sample();
    check_idle_outputs("midrst");

    mem[301] = 8'hFF;
    start_dump(9'd300, 8'h20, 8'h01);
    run(0, 0, 0, -1);
    verify("dumpE", 9'd300);
    chk("corr_sat_offset", obs_q[0], 8'hFF);

`ifdef TRACE_DUMP_ABORT_EN
    start_dump(9'd200, 8'h20, 8'h00);
    run(0, 0, 0, 10);
    hold_en = 1'b0;
    @(posedge clk); #1;
    tx_rdy = 1'b0;
    sample();
    wait_cnt = 0;
    while (!tx_valid && wait_cnt < 10) begin
      @(posedge clk); #1;
      wait_cnt++;
      sample();
    end
    chk("abort_stall_reached", tx_valid, 1);
    @(posedge clk); #1;
    abort = 1'b1; tx_rdy = 1'b1;
    sample();
    @(posedge clk); #1;
    abort = 1'b0;
    sample();
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_ram_en", ram_en, 0);
    chk("abort_busy", busy, 0);
    repeat (8) sample();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_clr", clr_cnt, 0);
    chk("abort_stays_idle", busy, 0);
    hold_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
